// File: rtl/usb_rx_bit_decoder.sv
// rtl/usb_rx_bit_decoder.sv - USB FS receive front end: sync, bit recovery, NRZI decode, destuff, byte assembly
// Optional stuff_err output port is enabled by defining USB_RX_STUFF_ERR_EN.
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_OFFSET = 3,
    parameter int STUFF_LEN     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus_in,
    input  logic       d_minus_in,
    output logic       d_edge,
    output logic       shift_enable,
    output logic [7:0] rcv_data,
    output logic       byte_received,
    output logic       eop
`ifdef USB_RX_STUFF_ERR_EN
    ,
    output logic       stuff_err
`endif
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {IDLE, RECEIVE, EOP} state_t;

    state_t          state_q, state_d;
    logic            dp_meta_q, dp_sync_q, dp_dly_q, dm_meta_q, dm_sync_q;
    logic            d_edge_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic            prev_q, prev_d;
    logic [OW-1:0]   ones_q, ones_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      data_q, data_d;
    logic            byte_q, byte_d;
    logic            eop_q, eop_d;
    logic            shift;
    logic            strobe, se0, line_bit, stuffed;
`ifdef USB_RX_STUFF_ERR_EN
    logic            serr_q, serr_d;
`endif

    assign strobe   = (state_q != IDLE) && (timer_q == TW'(SAMPLE_OFFSET));
    assign se0      = !dp_sync_q && !dm_sync_q;
    assign line_bit = (dp_sync_q == prev_q);
    assign stuffed  = (ones_q == OW'(STUFF_LEN));

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        prev_d   = prev_q;
        ones_d   = ones_q;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        eop_d    = eop_q;
        byte_d   = 1'b0;
        shift    = 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
        serr_d   = 1'b0;
`endif
        // Strobe uses the pre-edge timer; a coincident d_edge only resyncs for the next bit.
        if (state_q == IDLE || d_edge_q || timer_q == TW'(CLKS_PER_BIT - 1)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
        case (state_q)
            IDLE: begin
                if (d_edge_q) state_d = RECEIVE;
            end
            RECEIVE: begin
                if (strobe) begin
                    if (se0) begin
                        state_d  = EOP;
                        eop_d    = 1'b1;
                        bitcnt_d = '0;
                        ones_d   = '0;
                    end else begin
                        prev_d = dp_sync_q;
                        if (stuffed) begin
                            ones_d = '0;
`ifdef USB_RX_STUFF_ERR_EN
                            serr_d = line_bit;
`endif
                        end else begin
                            shift    = 1'b1;
                            data_d   = {line_bit, data_q[7:1]};
                            ones_d   = line_bit ? ones_q + OW'(1) : '0;
                            bitcnt_d = bitcnt_q + 3'd1;
                            byte_d   = (bitcnt_q == 3'd7);
                        end
                    end
                end
            end
            EOP: begin
                if (strobe && !se0) begin
                    state_d  = IDLE;
                    eop_d    = 1'b0;
                    bitcnt_d = '0;
                    ones_d   = '0;
                    prev_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_meta_q <= 1'b1;
            dp_sync_q <= 1'b1;
            dp_dly_q  <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_sync_q <= 1'b0;
            d_edge_q  <= 1'b0;
            state_q   <= IDLE;
            timer_q   <= '0;
            prev_q    <= 1'b1;
            ones_q    <= '0;
            bitcnt_q  <= '0;
            data_q    <= 8'h00;
            byte_q    <= 1'b0;
            eop_q     <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            serr_q    <= 1'b0;
`endif
        end else begin
            dp_meta_q <= d_plus_in;
            dp_sync_q <= dp_meta_q;
            dp_dly_q  <= dp_sync_q;
            dm_meta_q <= d_minus_in;
            dm_sync_q <= dm_meta_q;
            d_edge_q  <= dp_sync_q ^ dp_dly_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            prev_q    <= prev_d;
            ones_q    <= ones_d;
            bitcnt_q  <= bitcnt_d;
            data_q    <= data_d;
            byte_q    <= byte_d;
            eop_q     <= eop_d;
`ifdef USB_RX_STUFF_ERR_EN
            serr_q    <= serr_d;
`endif
        end
    end

    assign d_edge        = d_edge_q;
    assign shift_enable  = shift;
    assign rcv_data      = data_q;
    assign byte_received = byte_q;
    assign eop           = eop_q;
`ifdef USB_RX_STUFF_ERR_EN
    assign stuff_err     = serr_q;
`endif

endmodule
